// File: rtl/instr_sequencer.sv
// instr_sequencer
// Multi-cycle control sequencer for the 8-bit model machine. Steps each
// instruction through fetch, decode and execute beats, latches the decoder's
// one-hot operation lines during decode and drives the per-beat datapath
// controls. Owns the run/halt state of the machine.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   run               start request, only looked at in IDLE
//   movea..halt       decoder one-hot operation lines (16)
//   z, c              registered ALU flags from the datapath
//   in_valid          input port has data
//   out_ready         output port accepts data
//   dec_en            decoder enable
//   ir_ld, pc_inc, pc_ld, addr_sel, mem_rd, mem_wr
//                     IR / PC / memory controls
//   reg_we, reg_src   register file write and source select
//   alu_op, flag_we   ALU operation and flag update
//   in_ack, out_valid I/O handshake
//   instr_done        one-cycle pulse on the last beat of an instruction
//   halted            machine stopped by HALT
//   state             current state (debug)
//
// state    | meaning
// ---------+------------------------------------------------
// IDLE     | stopped, waiting for run
// FETCH    | read opcode at PC into IR, PC+1
// DECODE   | decoder enabled, op register latched
// EXEC     | single execute beat for ALU/move/jump ops
// WAIT_IN  | waiting for in_valid to load the input port
// WAIT_OUT | presenting output data until out_ready
// HALT     | stopped by HALT, only rst leaves
module instr_sequencer (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       movea,
  input  logic       moveb,
  input  logic       movec,
  input  logic       add,
  input  logic       sub,
  input  logic       and1,
  input  logic       not1,
  input  logic       rsr,
  input  logic       rsl,
  input  logic       jmp,
  input  logic       jz,
  input  logic       jc,
  input  logic       in1,
  input  logic       out1,
  input  logic       nop,
  input  logic       halt,
  input  logic       z,
  input  logic       c,
  input  logic       in_valid,
  input  logic       out_ready,
  output logic       dec_en,
  output logic       ir_ld,
  output logic       pc_inc,
  output logic       pc_ld,
  output logic       addr_sel,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       reg_we,
  output logic [1:0] reg_src,
  output logic [2:0] alu_op,
  output logic       flag_we,
  output logic       in_ack,
  output logic       out_valid,
  output logic       instr_done,
  output logic       halted,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FETCH    = 3'd1,
    S_DECODE   = 3'd2,
    S_EXEC     = 3'd3,
    S_WAIT_IN  = 3'd4,
    S_WAIT_OUT = 3'd5,
    S_HALT     = 3'd6
  } state_t;

  localparam int OP_MOVEA = 0;
  localparam int OP_MOVEB = 1;
  localparam int OP_MOVEC = 2;
  localparam int OP_ADD   = 3;
  localparam int OP_SUB   = 4;
  localparam int OP_AND   = 5;
  localparam int OP_NOT   = 6;
  localparam int OP_RSR   = 7;
  localparam int OP_RSL   = 8;
  localparam int OP_JMP   = 9;
  localparam int OP_JZ    = 10;
  localparam int OP_JC    = 11;
  localparam int OP_IN    = 12;
  localparam int OP_OUT   = 13;
  localparam int OP_NOP   = 14;
  localparam int OP_HALT  = 15;

  localparam logic [2:0] ALU_PASS = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;
  localparam logic [2:0] ALU_AND  = 3'b011;
  localparam logic [2:0] ALU_NOT  = 3'b100;
  localparam logic [2:0] ALU_SHR  = 3'b101;
  localparam logic [2:0] ALU_SHL  = 3'b110;

  state_t      state_q, state_d;
  logic [15:0] op_q, op_d;
  logic [15:0] lines;
  logic [15:0] pri;
  logic        jump_taken;

  assign lines = {halt, nop, out1, in1, jc, jz, jmp, rsl, rsr,
                  not1, and1, sub, add, movec, moveb, movea};

  // Reduce the decoder lines to at most one bit so that everything
  // downstream of the op register can assume a clean one-hot.
  always_comb begin
    pri = '0;
    if      (lines[OP_HALT])  pri[OP_HALT]  = 1'b1;
    else if (lines[OP_IN])    pri[OP_IN]    = 1'b1;
    else if (lines[OP_OUT])   pri[OP_OUT]   = 1'b1;
    else if (lines[OP_JMP])   pri[OP_JMP]   = 1'b1;
    else if (lines[OP_JZ])    pri[OP_JZ]    = 1'b1;
    else if (lines[OP_JC])    pri[OP_JC]    = 1'b1;
    else if (lines[OP_MOVEA]) pri[OP_MOVEA] = 1'b1;
    else if (lines[OP_MOVEB]) pri[OP_MOVEB] = 1'b1;
    else if (lines[OP_MOVEC]) pri[OP_MOVEC] = 1'b1;
    else if (lines[OP_ADD])   pri[OP_ADD]   = 1'b1;
    else if (lines[OP_SUB])   pri[OP_SUB]   = 1'b1;
    else if (lines[OP_AND])   pri[OP_AND]   = 1'b1;
    else if (lines[OP_NOT])   pri[OP_NOT]   = 1'b1;
    else if (lines[OP_RSR])   pri[OP_RSR]   = 1'b1;
    else if (lines[OP_RSL])   pri[OP_RSL]   = 1'b1;
    else if (lines[OP_NOP])   pri[OP_NOP]   = 1'b1;
  end

  // Flags are taken live in the EXEC beat, not at decode time.
  assign jump_taken = op_q[OP_JMP] | (op_q[OP_JZ] & z) | (op_q[OP_JC] & c);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    dec_en     = 1'b0;
    ir_ld      = 1'b0;
    pc_inc     = 1'b0;
    pc_ld      = 1'b0;
    addr_sel   = 1'b0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    reg_we     = 1'b0;
    reg_src    = 2'b00;
    alu_op     = ALU_PASS;
    flag_we    = 1'b0;
    in_ack     = 1'b0;
    out_valid  = 1'b0;
    instr_done = 1'b0;
    halted     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        mem_rd  = 1'b1;
        ir_ld   = 1'b1;
        pc_inc  = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        dec_en = 1'b1;
        op_d   = pri;
        if (pri[OP_HALT]) begin
          state_d = S_HALT;
        end else if (pri[OP_IN]) begin
          state_d = S_WAIT_IN;
        end else if (pri[OP_OUT]) begin
          state_d = S_WAIT_OUT;
        end else if (pri[OP_NOP] || (pri == '0)) begin
          // Illegal opcodes retire as a nop.
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        instr_done = 1'b1;
        state_d    = S_FETCH;
        if (op_q[OP_MOVEA]) begin
          reg_we = 1'b1;
        end
        if (op_q[OP_MOVEB]) begin
          addr_sel = 1'b1;
          mem_wr   = 1'b1;
        end
        if (op_q[OP_MOVEC]) begin
          addr_sel = 1'b1;
          mem_rd   = 1'b1;
          reg_we   = 1'b1;
          reg_src  = 2'b01;
        end
        if (|op_q[OP_RSL:OP_ADD]) begin
          reg_we  = 1'b1;
          flag_we = 1'b1;
          if      (op_q[OP_ADD]) alu_op = ALU_ADD;
          else if (op_q[OP_SUB]) alu_op = ALU_SUB;
          else if (op_q[OP_AND]) alu_op = ALU_AND;
          else if (op_q[OP_NOT]) alu_op = ALU_NOT;
          else if (op_q[OP_RSR]) alu_op = ALU_SHR;
          else                   alu_op = ALU_SHL;
        end
        // Jumps carry a second byte at PC: load it when taken, skip it if not.
        if (|op_q[OP_JC:OP_JMP]) begin
          mem_rd = 1'b1;
          pc_ld  = jump_taken;
          pc_inc = ~jump_taken;
        end
      end
      S_WAIT_IN: begin
        if (in_valid) begin
          reg_we     = 1'b1;
          reg_src    = 2'b10;
          in_ack     = 1'b1;
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end
      end
      S_WAIT_OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign state = state_q;

endmodule

// File: tb/tb_instr_sequencer.sv
module tb_instr_sequencer;

  logic        clk;
  logic        rst;
  logic        run;
  logic [15:0] dl;
  logic        z, c, in_valid, out_ready;
  logic        dec_en, ir_ld, pc_inc, pc_ld, addr_sel, mem_rd, mem_wr, reg_we;
  logic [1:0]  reg_src;
  logic [2:0]  alu_op;
  logic        flag_we, in_ack, out_valid, instr_done, halted;
  logic [2:0]  state;
  logic [17:0] outs;

  int checks;
  int failures;

  // decoder line positions in dl
  localparam int L_MOVEA = 0, L_MOVEB = 1, L_MOVEC = 2, L_ADD = 3, L_SUB = 4,
                 L_AND = 5, L_NOT = 6, L_RSR = 7, L_RSL = 8, L_JMP = 9,
                 L_JZ = 10, L_JC = 11, L_IN = 12, L_OUT = 13, L_NOP = 14,
                 L_HALT = 15;

  // bit masks into outs
  localparam logic [17:0] M_DEC  = 18'd1 << 17;
  localparam logic [17:0] M_IR   = 18'd1 << 16;
  localparam logic [17:0] M_INC  = 18'd1 << 15;
  localparam logic [17:0] M_LD   = 18'd1 << 14;
  localparam logic [17:0] M_AS   = 18'd1 << 13;
  localparam logic [17:0] M_RD   = 18'd1 << 12;
  localparam logic [17:0] M_WR   = 18'd1 << 11;
  localparam logic [17:0] M_WE   = 18'd1 << 10;
  localparam logic [17:0] M_SMEM = 18'd1 << 8;
  localparam logic [17:0] M_SIN  = 18'd2 << 8;
  localparam logic [17:0] M_FW   = 18'd1 << 4;
  localparam logic [17:0] M_ACK  = 18'd1 << 3;
  localparam logic [17:0] M_OV   = 18'd1 << 2;
  localparam logic [17:0] M_DONE = 18'd1 << 1;
  localparam logic [17:0] M_HALT = 18'd1;
  localparam logic [17:0] E_FETCH = M_RD | M_IR | M_INC;

  instr_sequencer dut (
    .clk(clk), .rst(rst), .run(run),
    .movea(dl[L_MOVEA]), .moveb(dl[L_MOVEB]), .movec(dl[L_MOVEC]),
    .add(dl[L_ADD]), .sub(dl[L_SUB]), .and1(dl[L_AND]), .not1(dl[L_NOT]),
    .rsr(dl[L_RSR]), .rsl(dl[L_RSL]), .jmp(dl[L_JMP]), .jz(dl[L_JZ]),
    .jc(dl[L_JC]), .in1(dl[L_IN]), .out1(dl[L_OUT]), .nop(dl[L_NOP]),
    .halt(dl[L_HALT]), .z(z), .c(c), .in_valid(in_valid), .out_ready(out_ready),
    .dec_en(dec_en), .ir_ld(ir_ld), .pc_inc(pc_inc), .pc_ld(pc_ld),
    .addr_sel(addr_sel), .mem_rd(mem_rd), .mem_wr(mem_wr), .reg_we(reg_we),
    .reg_src(reg_src), .alu_op(alu_op), .flag_we(flag_we), .in_ack(in_ack),
    .out_valid(out_valid), .instr_done(instr_done), .halted(halted),
    .state(state)
  );

  assign outs = {dec_en, ir_ld, pc_inc, pc_ld, addr_sel, mem_rd, mem_wr, reg_we,
                 reg_src, alu_op, flag_we, in_ack, out_valid, instr_done, halted};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance one clock and settle past the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; run = 1'b0; dl = '0; z = 0; c = 0; in_valid = 0; out_ready = 0;
    tick(); tick();
    rst = 1'b0; #1;
    checks++; if (state !== 3'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state); end
    checks++; if (outs !== 18'h0) begin failures++; $display("FAIL reset_outs got=%h exp=0", outs); end
    tick();
    checks++; if (state !== 3'd0) begin failures++; $display("FAIL idle_hold got=%0d exp=0", state); end
  endtask

  // ends with the machine in FETCH
  task automatic test_add();
    int dones;
    dones = 0;
    run = 1'b1; tick(); run = 1'b0; #1;
    checks++; if (state !== 3'd1) begin failures++; $display("FAIL add_fetch_state got=%0d exp=1", state); end
    checks++; if (outs !== E_FETCH) begin failures++; $display("FAIL add_fetch_outs got=%h exp=%h", outs, E_FETCH); end
    dl = 16'd1 << L_ADD;
    tick();
    checks++; if (state !== 3'd2) begin failures++; $display("FAIL add_dec_state got=%0d exp=2", state); end
    checks++; if (outs !== M_DEC) begin failures++; $display("FAIL add_dec_outs got=%h exp=%h", outs, M_DEC); end
    dones += int'(instr_done);
    tick(); dl = '0; #1;
    checks++; if (state !== 3'd3) begin failures++; $display("FAIL add_exec_state got=%0d exp=3", state); end
    checks++; if (outs !== (M_WE | M_FW | (18'd1 << 5) | M_DONE)) begin failures++; $display("FAIL add_exec_outs got=%h exp=%h", outs, M_WE | M_FW | (18'd1 << 5) | M_DONE); end
    dones += int'(instr_done);
    tick();
    checks++; if (state !== 3'd1) begin failures++; $display("FAIL add_back_fetch got=%0d exp=1", state); end
    dones += int'(instr_done);
    checks++; if (dones != 1) begin failures++; $display("FAIL add_done_count got=%0d exp=1", dones); end
  endtask

  task automatic test_alu_ops();
    int          lines [5] = '{L_SUB, L_AND, L_NOT, L_RSR, L_RSL};
    logic [17:0] codes [5] = '{18'd2, 18'd3, 18'd4, 18'd5, 18'd6};
    logic [17:0] exp;
    for (int i = 0; i < 5; i++) begin
      dl = 16'd1 << lines[i];
      tick(); tick(); dl = '0; #1;
      exp = M_WE | M_FW | (codes[i] << 5) | M_DONE;
      checks++; if (outs !== exp) begin failures++; $display("FAIL alu_op_%0d got=%h exp=%h", i, outs, exp); end
      tick();
    end
  endtask

  task automatic test_jumps();
    logic [15:0] jl  [5] = '{16'd1 << L_JZ, 16'd1 << L_JZ, 16'd1 << L_JC, 16'd1 << L_JC, 16'd1 << L_JMP};
    logic        zv  [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic        cv  [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic        tk  [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [17:0] exp;
    for (int i = 0; i < 5; i++) begin
      dl = jl[i];
      tick(); tick(); dl = '0;
      z = zv[i]; c = cv[i]; #1;
      exp = M_RD | M_DONE | (tk[i] ? M_LD : M_INC);
      checks++; if (outs !== exp) begin failures++; $display("FAIL jump_%0d got=%h exp=%h", i, outs, exp); end
      tick(); z = 0; c = 0;
    end
  endtask

  task automatic test_moves();
    dl = 16'd1 << L_MOVEC;
    tick(); tick(); dl = '0; #1;
    checks++; if (outs !== (M_AS | M_RD | M_WE | M_SMEM | M_DONE)) begin failures++; $display("FAIL movec got=%h exp=%h", outs, M_AS | M_RD | M_WE | M_SMEM | M_DONE); end
    tick();
    dl = 16'd1 << L_MOVEB;
    tick(); tick(); dl = '0; #1;
    checks++; if (outs !== (M_AS | M_WR | M_DONE)) begin failures++; $display("FAIL moveb got=%h exp=%h", outs, M_AS | M_WR | M_DONE); end
    tick();
    dl = 16'd1 << L_MOVEA;
    tick(); tick(); dl = '0; #1;
    checks++; if (outs !== (M_WE | M_DONE)) begin failures++; $display("FAIL movea got=%h exp=%h", outs, M_WE | M_DONE); end
    tick();
  endtask

  task automatic test_nop_illegal();
    dl = 16'd1 << L_NOP;
    tick(); #1;
    checks++; if (outs !== (M_DEC | M_DONE)) begin failures++; $display("FAIL nop_dec got=%h exp=%h", outs, M_DEC | M_DONE); end
    dl = '0;
    tick();
    checks++; if (state !== 3'd1) begin failures++; $display("FAIL nop_next got=%0d exp=1", state); end
    tick(); #1;
    checks++; if (outs !== (M_DEC | M_DONE)) begin failures++; $display("FAIL illegal_dec got=%h exp=%h", outs, M_DEC | M_DONE); end
    tick();
    checks++; if (state !== 3'd1) begin failures++; $display("FAIL illegal_next got=%0d exp=1", state); end
  endtask

  task automatic test_priority();
    dl = (16'd1 << L_JMP) | (16'd1 << L_MOVEA) | (16'd1 << L_ADD) | (16'd1 << L_NOP);
    tick(); tick(); dl = '0; #1;
    checks++; if (outs !== (M_RD | M_LD | M_DONE)) begin failures++; $display("FAIL prio_jmp got=%h exp=%h", outs, M_RD | M_LD | M_DONE); end
    tick();
    dl = (16'd1 << L_OUT) | (16'd1 << L_ADD) | (16'd1 << L_JZ);
    tick(); tick(); dl = '0; #1;
    checks++; if (state !== 3'd5) begin failures++; $display("FAIL prio_out got=%0d exp=5", state); end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
  endtask

  task automatic test_in_wait();
    int bad_we;
    bad_we = 0;
    dl = 16'd1 << L_IN;
    tick(); tick(); dl = '0;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (state !== 3'd4 || outs !== 18'h0) begin failures++; $display("FAIL in_wait_%0d state=%0d outs=%h exp state=4 outs=0", i, state, outs); end
      tick();
    end
    in_valid = 1'b1; #1;
    checks++; if (state !== 3'd4 || outs !== (M_WE | M_SIN | M_ACK | M_DONE)) begin failures++; $display("FAIL in_accept state=%0d outs=%h exp=%h", state, outs, M_WE | M_SIN | M_ACK | M_DONE); end
    tick(); in_valid = 1'b0; #1;
    checks++; if (state !== 3'd1) begin failures++; $display("FAIL in_next got=%0d exp=1", state); end
  endtask

  task automatic test_out_wait();
    int ov_run;
    ov_run = 0;
    dl = 16'd1 << L_OUT;
    tick(); tick(); dl = '0;
    for (int i = 0; i < 3; i++) begin
      out_ready = (i == 2); #1;
      ov_run += int'(out_valid);
      checks++; if (outs !== (M_OV | (i == 2 ? M_DONE : 18'h0))) begin failures++; $display("FAIL out_cycle_%0d got=%h exp=%h", i, outs, M_OV | (i == 2 ? M_DONE : 18'h0)); end
      tick();
    end
    out_ready = 1'b0; #1;
    checks++; if (ov_run != 3 || out_valid !== 1'b0 || state !== 3'd1) begin failures++; $display("FAIL out_end ov_cycles=%0d ov=%b state=%0d exp 3/0/1", ov_run, out_valid, state); end
  endtask

  task automatic test_reset_in_wait();
    int acks;
    acks = 0;
    dl = 16'd1 << L_IN;
    tick(); tick(); dl = '0; #1;
    acks += int'(in_ack);
    checks++; if (state !== 3'd4) begin failures++; $display("FAIL rstwait_pre got=%0d exp=4", state); end
    rst = 1'b1; tick(); rst = 1'b0; #1;
    acks += int'(in_ack);
    checks++; if (state !== 3'd0 || outs !== 18'h0) begin failures++; $display("FAIL rstwait_idle state=%0d outs=%h exp 0/0", state, outs); end
    in_valid = 1'b1; tick(); #1;
    acks += int'(in_ack);
    in_valid = 1'b0;
    checks++; if (acks != 0 || state !== 3'd0) begin failures++; $display("FAIL rstwait_ack acks=%0d state=%0d exp 0/0", acks, state); end
    run = 1'b1; tick(); run = 1'b0;
  endtask

  task automatic test_halt();
    int bad;
    bad = 0;
    dl = 16'd1 << L_HALT;
    tick(); #1;
    checks++; if (outs !== M_DEC) begin failures++; $display("FAIL halt_dec got=%h exp=%h", outs, M_DEC); end
    tick(); dl = '0;
    for (int i = 0; i < 20; i++) begin
      run = i[0]; #1;
      if (state !== 3'd6 || outs !== M_HALT) bad++;
      tick();
    end
    run = 1'b0;
    checks++; if (bad != 0) begin failures++; $display("FAIL halt_sticky bad_cycles=%0d exp=0", bad); end
    rst = 1'b1; tick(); rst = 1'b0; #1;
    checks++; if (state !== 3'd0 || halted !== 1'b0) begin failures++; $display("FAIL halt_reset state=%0d halted=%b exp 0/0", state, halted); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_add();
    test_alu_ops();
    test_jumps();
    test_moves();
    test_nop_illegal();
    test_priority();
    test_in_wait();
    test_out_wait();
    test_reset_in_wait();
    test_halt();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
